// File: rtl/pcie_perst_seq_pkg.sv
// Shared types and helpers for the PCIe PERST# reset sequencer.
//   seq_state_e    : sequencer state, encoded as exposed on seq_state
//   max_cycles_w() : shared counter width for the largest cycle count
package pcie_perst_seq_pkg;

    typedef enum logic [2:0] {
        StPorHold  = 3'd0,
        StCfgWait  = 3'd1,
        StLinkWait = 3'd2,
        StLinkUp   = 3'd3,
        StPerstLow = 3'd4,
        StFail     = 3'd5
    } seq_state_e;

    // Width of a counter that must reach the largest of the given cycle counts.
    // The extra bit leaves headroom so the terminal compare never wraps.
    function automatic int unsigned max_cycles_w(input int unsigned a,
                                                 input int unsigned b,
                                                 input int unsigned c,
                                                 input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/cdc_sync_2ff.sv
// Two-flop synchronizer for a bundle of independent single-bit level signals.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, flops clear to 0
//   d_i    : asynchronous inputs
//   q_o    : synchronized outputs, two cycles of latency
module cdc_sync_2ff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] sync1_q;
    logic [Width-1:0] sync2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    assign q_o = sync2_q;

endmodule

// File: rtl/pcie_perst_sequencer.sv
// Reset sequencer for one PCIe controller: POR hold, wait for config load,
// PERST# release, link-up supervision with timeout and PERST# retry pulses.
//   sys_clk     : sequencer clock
//   sys_rst_n   : asynchronous active-low reset
//   cfg_done    : config load complete (async, synchronized here)
//   link_up     : controller link-up (async, synchronized here)
//   restart_req : single-cycle request for a full link restart
//   por_rst_n   : POR/LPD reset to the controller, active-low
//   perst_n     : PERST# to the controller, active-low
//   user_reset  : user-logic reset, always the complement of perst_n
//   link_ok     : link up and stable
//   link_fail   : retries exhausted, sticky until restart_req or reset
//   retry_cnt   : retries since last reset or restart
//   seq_state   : current state, for debug
module pcie_perst_sequencer
    import pcie_perst_seq_pkg::*;
#(
    parameter int unsigned POR_CYCLES       = 500,
    parameter int unsigned CFG_CYCLES       = 12300,
    parameter int unsigned CFG_MIN_CYCLES   = 64,
    parameter int unsigned LINK_TIMEOUT     = 200000,
    parameter int unsigned LINK_STABLE      = 16,
    parameter int unsigned PERST_LOW_CYCLES = 1000,
    parameter int unsigned MAX_RETRIES      = 3
) (
    input  logic                               sys_clk,
    input  logic                               sys_rst_n,
    input  logic                               cfg_done,
    input  logic                               link_up,
    input  logic                               restart_req,
    output logic                               por_rst_n,
    output logic                               perst_n,
    output logic                               user_reset,
    output logic                               link_ok,
    output logic                               link_fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
    output logic [2:0]                         seq_state
);

    localparam int unsigned CntW   = max_cycles_w(POR_CYCLES, CFG_CYCLES, LINK_TIMEOUT,
                                                  PERST_LOW_CYCLES);
    localparam int unsigned StabW  = $clog2(LINK_STABLE + 1);
    localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);

    localparam logic [CntW-1:0]   PorLast    = CntW'(POR_CYCLES - 1);
    localparam logic [CntW-1:0]   CfgLast    = CntW'(CFG_CYCLES - 1);
    localparam logic [CntW-1:0]   CfgMinLast = CntW'(CFG_MIN_CYCLES - 1);
    localparam logic [CntW-1:0]   LinkLast   = CntW'(LINK_TIMEOUT - 1);
    localparam logic [CntW-1:0]   PerstLast  = CntW'(PERST_LOW_CYCLES - 1);
    localparam logic [StabW-1:0]  StabDone   = StabW'(LINK_STABLE);
    localparam logic [RetryW-1:0] RetryMax   = RetryW'(MAX_RETRIES);

    // Synchronized inputs: bit 0 cfg_done, bit 1 link_up.
    logic [1:0] sync_s;
    logic       cfg_s;
    logic       link_s;

    cdc_sync_2ff #(
        .Width (2)
    ) u_sync (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst_n),
        .d_i    ({link_up, cfg_done}),
        .q_o    (sync_s)
    );

    assign cfg_s  = sync_s[0];
    assign link_s = sync_s[1];

    seq_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [StabW-1:0]  stab_q, stab_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic              por_q, por_d;
    logic              perst_q, perst_d;
    logic              user_reset_q;
    logic              link_ok_q, link_ok_d;
    logic              link_fail_q, link_fail_d;
    logic              restart_take;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CntW'(1);
        stab_d       = '0;
        retry_d      = retry_q;
        por_d        = por_q;
        perst_d      = perst_q;
        link_ok_d    = link_ok_q;
        link_fail_d  = link_fail_q;
        restart_take = restart_req && (state_q != StPorHold);

        case (state_q)
            StPorHold: begin
                if (cnt_q == PorLast) begin
                    por_d   = 1'b1;
                    state_d = StCfgWait;
                end
            end
            StCfgWait: begin
                // Timeout releases PERST# anyway; no error is flagged.
                if ((cfg_s && (cnt_q >= CfgMinLast)) || (cnt_q == CfgLast)) begin
                    perst_d = 1'b1;
                    state_d = StLinkWait;
                end
            end
            StLinkWait: begin
                stab_d = link_s ? stab_q + StabW'(1) : '0;
                // Stability is tested before the timeout so link-up wins a tie.
                if (stab_q == StabDone) begin
                    link_ok_d = 1'b1;
                    state_d   = StLinkUp;
                end else if (cnt_q == LinkLast) begin
                    perst_d = 1'b0;
                    if (retry_q < RetryMax) begin
                        retry_d = retry_q + RetryW'(1);
                        state_d = StPerstLow;
                    end else begin
                        link_fail_d = 1'b1;
                        state_d     = StFail;
                    end
                end
            end
            StLinkUp: begin
                cnt_d = '0;
                if (!link_s) begin
                    link_ok_d = 1'b0;
                    state_d   = StLinkWait;
                end
            end
            StPerstLow: begin
                if (cnt_q == PerstLast) begin
                    perst_d = 1'b1;
                    state_d = StLinkWait;
                end
            end
            StFail: begin
                cnt_d = '0;
            end
            default: begin
                state_d = StPorHold;
            end
        endcase

        // Restart overrides every other event in the same cycle.
        if (restart_take) begin
            perst_d     = 1'b0;
            link_ok_d   = 1'b0;
            link_fail_d = 1'b0;
            retry_d     = '0;
            state_d     = StPerstLow;
        end

        // A restart from PERST_LOW re-enters it, so it also restarts the count.
        if ((state_d != state_q) || restart_take) begin
            cnt_d  = '0;
            stab_d = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= StPorHold;
            cnt_q        <= '0;
            stab_q       <= '0;
            retry_q      <= '0;
            por_q        <= 1'b0;
            perst_q      <= 1'b0;
            user_reset_q <= 1'b1;
            link_ok_q    <= 1'b0;
            link_fail_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stab_q       <= stab_d;
            retry_q      <= retry_d;
            por_q        <= por_d;
            perst_q      <= perst_d;
            user_reset_q <= ~perst_d;
            link_ok_q    <= link_ok_d;
            link_fail_q  <= link_fail_d;
        end
    end

    assign por_rst_n  = por_q;
    assign perst_n    = perst_q;
    assign user_reset = user_reset_q;
    assign link_ok    = link_ok_q;
    assign link_fail  = link_fail_q;
    assign retry_cnt  = retry_q;
    assign seq_state  = state_q;

endmodule

// File: tb/tb_pcie_perst_sequencer.sv
// Self-checking bench for pcie_perst_sequencer. Expected event times are
// derived from the sequencing rules with plain arithmetic on edge counts.
module tb_pcie_perst_sequencer;

    localparam int PorCycles   = 500;
    localparam int CfgCycles   = 12300;
    localparam int CfgMin      = 64;
    localparam int LinkTimeout = 100;
    localparam int LinkStable  = 16;
    localparam int PerstLow    = 1000;
    localparam int MaxRetries  = 3;
    localparam int SyncLat     = 2;

    localparam int SigPor    = 0;
    localparam int SigPerst  = 1;
    localparam int SigLinkOk = 2;

    logic       sys_clk     = 1'b0;
    logic       sys_rst_n   = 1'b0;
    logic       cfg_done    = 1'b0;
    logic       link_up     = 1'b0;
    logic       restart_req = 1'b0;
    logic       por_rst_n;
    logic       perst_n;
    logic       user_reset;
    logic       link_ok;
    logic       link_fail;
    logic [1:0] retry_cnt;
    logic [2:0] seq_state;

    int tests = 0;
    int fails = 0;

    pcie_perst_sequencer #(
        .POR_CYCLES       (PorCycles),
        .CFG_CYCLES       (CfgCycles),
        .CFG_MIN_CYCLES   (CfgMin),
        .LINK_TIMEOUT     (LinkTimeout),
        .LINK_STABLE      (LinkStable),
        .PERST_LOW_CYCLES (PerstLow),
        .MAX_RETRIES      (MaxRetries)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .cfg_done    (cfg_done),
        .link_up     (link_up),
        .restart_req (restart_req),
        .por_rst_n   (por_rst_n),
        .perst_n     (perst_n),
        .user_reset  (user_reset),
        .link_ok     (link_ok),
        .link_fail   (link_fail),
        .retry_cnt   (retry_cnt),
        .seq_state   (seq_state)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Counts rising edges until the selected output reaches level; gives
    // limit+1 when the bound expires so the caller's comparison fails.
    task automatic count_until(input int which, input logic level, input int limit,
                               output int n);
        logic v;
        n = 0;
        while (n <= limit) begin
            tick();
            n++;
            case (which)
                SigPor:   v = por_rst_n;
                SigPerst: v = perst_n;
                default:  v = link_ok;
            endcase
            if (v === level) break;
        end
    endtask

    task automatic test_reset();
        int n;
        sys_rst_n = 1'b0;
        #20;
        tests++;
        if ({por_rst_n, perst_n, user_reset, link_ok, link_fail} !== 5'b00100) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 00100",
                     {por_rst_n, perst_n, user_reset, link_ok, link_fail});
        end
        tests++;
        if (seq_state !== 3'd0 || retry_cnt !== 2'd0) begin
            fails++;
            $display("FAIL reset_state: got state %0d retry %0d want 0 0", seq_state, retry_cnt);
        end
        tick();
        sys_rst_n = 1'b1;
        count_until(SigPor, 1'b1, PorCycles + 50, n);
        tests++;
        if (n !== PorCycles) begin
            fails++;
            $display("FAIL por_release: got %0d cycles want %0d", n, PorCycles);
        end
        tests++;
        if (seq_state !== 3'd1 || perst_n !== 1'b0) begin
            fails++;
            $display("FAIL cfg_wait_entry: got state %0d perst %b want 1 0", seq_state, perst_n);
        end
    endtask

    task automatic test_cfg_timeout();
        int n;
        count_until(SigPerst, 1'b1, CfgCycles + 50, n);
        tests++;
        if (n !== CfgCycles) begin
            fails++;
            $display("FAIL cfg_timeout: got %0d cycles want %0d", n, CfgCycles);
        end
        tests++;
        if (user_reset !== 1'b0 || seq_state !== 3'd2) begin
            fails++;
            $display("FAIL perst_release: got user_reset %b state %0d want 0 2",
                     user_reset, seq_state);
        end
    endtask

    task automatic test_link_stable();
        int n;
        link_up = 1'b1;
        count_until(SigLinkOk, 1'b1, 80, n);
        tests++;
        if (n !== LinkStable + SyncLat + 1) begin
            fails++;
            $display("FAIL link_stable: got %0d cycles want %0d", n, LinkStable + SyncLat + 1);
        end
        tests++;
        if (seq_state !== 3'd3) begin
            fails++;
            $display("FAIL link_up_state: got %0d want 3", seq_state);
        end
    endtask

    task automatic test_link_drop();
        int n;
        link_up = 1'b0;
        count_until(SigLinkOk, 1'b0, 20, n);
        tests++;
        if (n !== SyncLat + 1) begin
            fails++;
            $display("FAIL link_drop: got %0d cycles want %0d", n, SyncLat + 1);
        end
        tests++;
        if (seq_state !== 3'd2 || perst_n !== 1'b1 || retry_cnt !== 2'd0) begin
            fails++;
            $display("FAIL link_drop_state: got state %0d perst %b retry %0d want 2 1 0",
                     seq_state, perst_n, retry_cnt);
        end
    endtask

    task automatic test_glitch();
        int n;
        int g;
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
        tests++;
        if (seq_state !== 3'd4 || perst_n !== 1'b0 || user_reset !== 1'b1) begin
            fails++;
            $display("FAIL restart_from_wait: got state %0d perst %b user %b want 4 0 1",
                     seq_state, perst_n, user_reset);
        end
        count_until(SigPerst, 1'b1, PerstLow + 50, n);
        tests++;
        if (n !== PerstLow) begin
            fails++;
            $display("FAIL restart_perst_low: got %0d cycles want %0d", n, PerstLow);
        end
        // One-cycle dropout restarts the stable run one cycle after the glitch.
        g = $urandom_range(1, 12);
        link_up = 1'b1;
        n = 0;
        while (n <= 200) begin
            tick();
            n++;
            if (link_ok === 1'b1) break;
            if (n == g) link_up = 1'b0;
            if (n == g + 1) link_up = 1'b1;
        end
        tests++;
        if (n !== g + 1 + LinkStable + SyncLat + 1) begin
            fails++;
            $display("FAIL link_glitch: glitch at %0d got %0d cycles want %0d",
                     g, n, g + 1 + LinkStable + SyncLat + 1);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b0;
        #1;
        tests++;
        if ({por_rst_n, perst_n, user_reset, link_ok} !== 4'b0010 || seq_state !== 3'd0) begin
            fails++;
            $display("FAIL async_reset: got %b state %0d want 0010 state 0",
                     {por_rst_n, perst_n, user_reset, link_ok}, seq_state);
        end
        link_up = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        count_until(SigPor, 1'b1, PorCycles + 50, n);
        tests++;
        if (n !== PorCycles) begin
            fails++;
            $display("FAIL por_after_reset: got %0d cycles want %0d", n, PorCycles);
        end
    endtask

    task automatic test_cfg_early(input int t);
        int n;
        int exp;
        tick();
        sys_rst_n = 1'b0;
        cfg_done  = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        count_until(SigPor, 1'b1, PorCycles + 50, n);
        tests++;
        if (n !== PorCycles) begin
            fails++;
            $display("FAIL por_cfg_run: got %0d cycles want %0d", n, PorCycles);
        end
        for (int k = 0; k < t; k++) tick();
        cfg_done = 1'b1;
        n = t;
        while (n <= CfgCycles + 50) begin
            tick();
            n++;
            if (perst_n === 1'b1) break;
        end
        exp = (t + SyncLat + 1 > CfgMin) ? t + SyncLat + 1 : CfgMin;
        if (exp > CfgCycles) exp = CfgCycles;
        tests++;
        if (n !== exp) begin
            fails++;
            $display("FAIL cfg_early: cfg_done at %0d got %0d want %0d", t, n, exp);
        end
        cfg_done = 1'b0;
    endtask

    task automatic test_retries();
        int n;
        for (int k = 1; k <= MaxRetries; k++) begin
            count_until(SigPerst, 1'b0, LinkTimeout + 50, n);
            tests++;
            if (n !== LinkTimeout || retry_cnt !== k[1:0] || seq_state !== 3'd4) begin
                fails++;
                $display("FAIL retry_%0d: got %0d cycles retry %0d state %0d want %0d %0d 4",
                         k, n, retry_cnt, seq_state, LinkTimeout, k);
            end
            count_until(SigPerst, 1'b1, PerstLow + 50, n);
            tests++;
            if (n !== PerstLow) begin
                fails++;
                $display("FAIL retry_pulse_%0d: got %0d cycles want %0d", k, n, PerstLow);
            end
        end
        count_until(SigPerst, 1'b0, LinkTimeout + 50, n);
        tests++;
        if (n !== LinkTimeout || link_fail !== 1'b1 || seq_state !== 3'd5) begin
            fails++;
            $display("FAIL link_fail: got %0d cycles fail %b state %0d want %0d 1 5",
                     n, link_fail, seq_state, LinkTimeout);
        end
        for (int k = 0; k < 50; k++) tick();
        tests++;
        if (link_fail !== 1'b1 || perst_n !== 1'b0 || por_rst_n !== 1'b1 || retry_cnt !== 2'd3) begin
            fails++;
            $display("FAIL fail_sticky: got fail %b perst %b por %b retry %0d want 1 0 1 3",
                     link_fail, perst_n, por_rst_n, retry_cnt);
        end
    endtask

    task automatic test_restart_from_fail();
        int n;
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
        tests++;
        if (link_fail !== 1'b0 || retry_cnt !== 2'd0 || seq_state !== 3'd4) begin
            fails++;
            $display("FAIL restart_fail: got fail %b retry %0d state %0d want 0 0 4",
                     link_fail, retry_cnt, seq_state);
        end
        count_until(SigPerst, 1'b1, PerstLow + 50, n);
        tests++;
        if (n !== PerstLow || seq_state !== 3'd2) begin
            fails++;
            $display("FAIL restart_fail_pulse: got %0d cycles state %0d want %0d 2",
                     n, seq_state, PerstLow);
        end
    endtask

    task automatic test_restart_timeout();
        int n;
        count_until(SigPerst, 1'b0, LinkTimeout + 50, n);
        tests++;
        if (n !== LinkTimeout || retry_cnt !== 2'd1) begin
            fails++;
            $display("FAIL pre_retry: got %0d cycles retry %0d want %0d 1", n, retry_cnt, LinkTimeout);
        end
        count_until(SigPerst, 1'b1, PerstLow + 50, n);
        for (int k = 0; k < LinkTimeout - 1; k++) tick();
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
        tests++;
        if (seq_state !== 3'd4 || retry_cnt !== 2'd0 || perst_n !== 1'b0) begin
            fails++;
            $display("FAIL restart_vs_timeout: got state %0d retry %0d perst %b want 4 0 0",
                     seq_state, retry_cnt, perst_n);
        end
        count_until(SigPerst, 1'b1, PerstLow + 50, n);
        tests++;
        if (n !== PerstLow) begin
            fails++;
            $display("FAIL restart_vs_timeout_pulse: got %0d cycles want %0d", n, PerstLow);
        end
    endtask

    initial begin
        test_reset();
        test_cfg_timeout();
        test_link_stable();
        test_link_drop();
        test_glitch();
        test_mid_reset();
        test_cfg_early(10);
        test_cfg_early(100);
        test_cfg_early($urandom_range(0, 150));
        test_retries();
        test_restart_from_fail();
        test_restart_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
